// File: rtl/opll_bus_pkg.sv
// Shared types and constants for the OPLL register-write front end.
package opll_bus_pkg;

  // Default chip wait times, in OPLL master-clock (cen) ticks.
  localparam int OPLL_ADDR_WAIT = 12;
  localparam int OPLL_DATA_WAIT = 84;

  // Bus-replay sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_STB  = 3'd1,
    ST_ADDR_WAIT = 3'd2,
    ST_DATA_STB  = 3'd3,
    ST_DATA_WAIT = 3'd4
  } opll_state_e;

  // One queued register write.
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } opll_word_t;

  // True in the states that drive cs_n/wr_n low.
  function automatic logic is_strobe(input opll_state_e s);
    return (s == ST_ADDR_STB) || (s == ST_DATA_STB);
  endfunction

endpackage

// File: rtl/opll_reg_write_queue_if.sv
// Write-request handshake between a bus master and the OPLL write queue.
interface opll_reg_write_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_reg;
  logic [7:0] in_data;

  modport master (output in_valid, output in_reg, output in_data, input in_ready);
  modport slave  (input in_valid, input in_reg, input in_data, output in_ready);
endinterface

// File: rtl/opll_wr_fifo.sv
// DEPTH x 16 synchronous FIFO with first-word fall-through head, flush and
// registered occupancy / ready flags.
module opll_wr_fifo
  import opll_bus_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  opll_word_t       i_word,
  output opll_word_t       o_head,
  output logic             o_ready,
  output logic [LVL_W-1:0] o_level
);

  opll_word_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             r_ready;
  logic [LVL_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;

  // Flush wins over both push and pop; a full FIFO silently ignores pushes.
  assign w_push = i_push & r_ready & ~i_flush;
  assign w_pop  = i_pop & (r_count != '0) & ~i_flush;

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != LVL_W'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_word;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_level = r_count;

endmodule

// File: rtl/opll_reg_write_queue.sv
// Buffered OPLL CPU-bus front end: queues register writes and replays each
// one as an address strobe then a data strobe with the chip wait times.
// Bus outputs are a registered decode of the sequencer state, so they trail
// the state by one clock (pop edge, then strobe visible on the next edge).
module opll_reg_write_queue
  import opll_bus_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WAIT  = OPLL_ADDR_WAIT,
  parameter int DATA_WAIT  = OPLL_DATA_WAIT,
  parameter int STROBE_LEN = 1,
  parameter int CNT_W      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  opll_reg_write_queue_if.slave  wr_if,
  input  logic                   flush,
  output logic                   opll_cs_n,
  output logic                   opll_wr_n,
  output logic                   opll_a0,
  output logic [7:0]             opll_d,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  opll_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  opll_word_t            r_hold;
  logic                  r_cs_n;
  logic                  r_wr_n;
  logic                  r_a0;
  logic [7:0]            r_d;
  logic                  r_busy;
  opll_word_t            w_in_word;
  opll_word_t            w_head;
  logic                  w_pop;
  logic                  w_in_ready;
  logic [$clog2(DEPTH):0] w_level;

  assign w_in_word = {wr_if.in_reg, wr_if.in_data};

  // The sequencer takes a new entry only on a cen tick while idle, and never
  // while a flush is discarding the queue.
  assign w_pop = cen & (r_state == ST_IDLE) & (w_level != '0) & ~flush;

  opll_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_if.in_valid),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_word  (w_in_word),
    .o_head  (w_head),
    .o_ready (w_in_ready),
    .o_level (w_level)
  );

  // Sequencer: state/counter advance on cen ticks; bus outputs decode the current state every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_a0    <= 1'b0;
      r_d     <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      r_cs_n <= ~is_strobe(r_state);
      r_wr_n <= ~is_strobe(r_state);
      r_busy <= (r_state != ST_IDLE) || (w_level != '0);
      // a0/d only change on a strobe so the data value lingers until the next address phase
      if (r_state == ST_ADDR_STB) begin
        r_a0 <= 1'b0;
        r_d  <= r_hold.reg_addr;
      end else if (r_state == ST_DATA_STB) begin
        r_a0 <= 1'b1;
        r_d  <= r_hold.data;
      end

      if (cen) begin
        case (r_state)
          ST_IDLE: begin
            if (w_pop) begin
              r_hold  <= w_head;
              r_cnt   <= CNT_W'(STROBE_LEN);
              r_state <= ST_ADDR_STB;
            end
          end
          ST_ADDR_STB: begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt   <= CNT_W'(ADDR_WAIT);
              r_state <= ST_ADDR_WAIT;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_ADDR_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt   <= CNT_W'(STROBE_LEN);
              r_state <= ST_DATA_STB;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_DATA_STB: begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt   <= CNT_W'(DATA_WAIT);
              r_state <= ST_DATA_WAIT;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_DATA_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign wr_if.in_ready = w_in_ready;
  assign opll_cs_n      = r_cs_n;
  assign opll_wr_n      = r_wr_n;
  assign opll_a0        = r_a0;
  assign opll_d         = r_d;
  assign level          = w_level;
  assign busy           = r_busy;

endmodule

// File: tb/tb_opll_reg_write_queue.sv
// Self-checking bench for opll_reg_write_queue: a directed table, hand-written
// corner sequences and randomized traffic, all compared every clock against
// a transaction-level timeline model.
module tb_opll_reg_write_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 5;
  localparam int SL    = 1;
  localparam int TOTAL = 2 * SL + AW + DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       flush = 1'b0;
  logic       opll_cs_n, opll_wr_n, opll_a0;
  logic [7:0] opll_d;
  logic [3:0] level;
  logic       busy;

  opll_reg_write_queue_if wr_if ();

  opll_reg_write_queue #(
    .DEPTH(DEPTH), .ADDR_WAIT(AW), .DATA_WAIT(DW), .STROBE_LEN(SL), .CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr_if(wr_if), .flush(flush),
    .opll_cs_n(opll_cs_n), .opll_wr_n(opll_wr_n), .opll_a0(opll_a0),
    .opll_d(opll_d), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cen_mode = 0;   // 0: set by hand, 1: every 2nd clock, 2: random

  // Reference model: queue of pending words plus elapsed cen ticks of the
  // transaction currently on the bus.
  logic [15:0] m_q[$];
  logic        m_active;
  int          m_el;
  logic [15:0] m_cur;
  logic        e_cs_n, e_a0, e_busy;
  logic [7:0]  e_d;

  // Observed bus strobes {a0, d}, logged at each cs_n falling edge.
  logic [8:0]  obs_log[$];
  logic        prev_cs_obs;

  typedef struct {
    logic       valid;
    logic [7:0] rg;
    logic [7:0] dt;
    logic       exp_cs_n;
    logic       exp_a0;
    logic [7:0] exp_d;
    logic [3:0] exp_level;
    logic       exp_busy;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_el = 0;
    m_cur = 16'h0000;
    e_cs_n = 1'b1;
    e_a0 = 1'b0;
    e_d = 8'h00;
    e_busy = 1'b0;
    obs_log.delete();
    prev_cs_obs = 1'b1;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare everything.
  task automatic step();
    logic strobe_b, data_b, ready_b;
    @(posedge clk);
    strobe_b = m_active && ((m_el < SL) || (m_el >= SL + AW && m_el < 2 * SL + AW));
    data_b   = (m_el >= SL + AW);
    if (strobe_b) begin
      e_a0 = data_b;
      e_d  = data_b ? m_cur[7:0] : m_cur[15:8];
    end
    e_cs_n  = !strobe_b;
    e_busy  = m_active || (m_q.size() != 0);
    ready_b = (m_q.size() != DEPTH);
    if (cen) begin
      if (m_active) begin
        m_el++;
        if (m_el == TOTAL) m_active = 1'b0;
      end else if (m_q.size() != 0 && !flush) begin
        m_cur = m_q.pop_front();
        m_active = 1'b1;
        m_el = 0;
      end
    end
    if (flush) m_q.delete();
    else if (wr_if.in_valid && ready_b) m_q.push_back({wr_if.in_reg, wr_if.in_data});
    #1;
    chk("bus_cycle",
        {15'd0, opll_cs_n, opll_wr_n, opll_a0, opll_d, level, wr_if.in_ready, busy},
        {15'd0, e_cs_n, e_cs_n, e_a0, e_d, 4'(m_q.size()), (m_q.size() != DEPTH), e_busy});
    if (!opll_cs_n && prev_cs_obs) obs_log.push_back({opll_a0, opll_d});
    prev_cs_obs = opll_cs_n;
    cyc++;
    if (cen_mode == 1) cen = (cyc % 2 == 0) ? 1'b1 : 1'b0;
    else if (cen_mode == 2) cen = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    wr_if.in_valid = 1'b0;
    wr_if.in_reg = 8'h00;
    wr_if.in_data = 8'h00;
    flush = 1'b0;
    cen = 1'b0;
    cen_mode = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_state", {15'd0, opll_cs_n, opll_wr_n, opll_a0, opll_d, level, wr_if.in_ready, busy},
        {15'd0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push(input logic [7:0] rg, input logic [7:0] dt);
    wr_if.in_valid = 1'b1;
    wr_if.in_reg = rg;
    wr_if.in_data = dt;
    step();
    wr_if.in_valid = 1'b0;
  endtask

  // Run until the model reports nothing left, then confirm the DUT went quiet too.
  task automatic drain();
    wr_if.in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3000 && (m_active || m_q.size() != 0); i++) step();
    step();
    step();
    chk("drain_idle", {27'd0, busy, level}, 32'd0);
  endtask

  task automatic check_log(input logic [15:0] words[$]);
    chk("log_len", obs_log.size(), 2 * words.size());
    for (int i = 0; i < words.size() && 2 * i + 1 < obs_log.size(); i++) begin
      chk("log_addr", {23'd0, obs_log[2 * i]},     {23'd0, 1'b0, words[i][15:8]});
      chk("log_data", {23'd0, obs_log[2 * i + 1]}, {23'd0, 1'b1, words[i][7:0]});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words[$];
    int guard;
    model_reset();

    // Single write with cen=1 every clock: {cs_n, a0, d, level, busy} after each edge.
    tbl[0] = '{valid: 1'b1, rg: 8'h10, dt: 8'h55, exp_cs_n: 1'b1, exp_a0: 1'b0, exp_d: 8'h00, exp_level: 4'd1, exp_busy: 1'b0};
    tbl[1] = '{valid: 1'b0, rg: 8'h00, dt: 8'h00, exp_cs_n: 1'b1, exp_a0: 1'b0, exp_d: 8'h00, exp_level: 4'd0, exp_busy: 1'b1};
    tbl[2] = '{valid: 1'b0, rg: 8'h00, dt: 8'h00, exp_cs_n: 1'b0, exp_a0: 1'b0, exp_d: 8'h10, exp_level: 4'd0, exp_busy: 1'b1};
    for (int i = 3; i <= 5; i++)
      tbl[i] = '{valid: 1'b0, rg: 8'h00, dt: 8'h00, exp_cs_n: 1'b1, exp_a0: 1'b0, exp_d: 8'h10, exp_level: 4'd0, exp_busy: 1'b1};
    tbl[6] = '{valid: 1'b0, rg: 8'h00, dt: 8'h00, exp_cs_n: 1'b0, exp_a0: 1'b1, exp_d: 8'h55, exp_level: 4'd0, exp_busy: 1'b1};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{valid: 1'b0, rg: 8'h00, dt: 8'h00, exp_cs_n: 1'b1, exp_a0: 1'b1, exp_d: 8'h55, exp_level: 4'd0, exp_busy: 1'b1};
    tbl[12] = '{valid: 1'b0, rg: 8'h00, dt: 8'h00, exp_cs_n: 1'b1, exp_a0: 1'b1, exp_d: 8'h55, exp_level: 4'd0, exp_busy: 1'b0};

    do_reset();
    cen = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wr_if.in_valid = tbl[i].valid;
      wr_if.in_reg = tbl[i].rg;
      wr_if.in_data = tbl[i].dt;
      step();
      chk("table_row", {17'd0, opll_cs_n, opll_a0, opll_d, level, busy},
          {17'd0, tbl[i].exp_cs_n, tbl[i].exp_a0, tbl[i].exp_d, tbl[i].exp_level, tbl[i].exp_busy});
    end

    // Fill with cen stopped: 8 accepted, the 9th held off, then drain in order.
    do_reset();
    words.delete();
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h20 + i), 8'(8'hA0 + i));
      if (i < 8) words.push_back({8'(8'h20 + i), 8'(8'hA0 + i)});
      if (i == 7) begin
        chk("fill_level8", {28'd0, level}, 32'd8);
        chk("fill_ready0", {31'd0, wr_if.in_ready}, 32'd0);
      end
    end
    chk("fill_9th_held", {28'd0, level}, 32'd8);
    cen_mode = 1;
    drain();
    check_log(words);

    // Push coinciding with the idle pop at level 3.
    do_reset();
    words.delete();
    for (int i = 0; i < 3; i++) begin
      push(8'(8'h30 + i), 8'(8'hC0 + i));
      words.push_back({8'(8'h30 + i), 8'(8'hC0 + i)});
    end
    cen = 1'b1;
    push(8'h3F, 8'hCF);
    words.push_back({8'h3F, 8'hCF});
    chk("pushpop_level", {28'd0, level}, 32'd3);
    cen_mode = 1;
    drain();
    check_log(words);

    // Flush during ADDR_WAIT with 4 still queued; a same-cycle push is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 8'(8'hD0 + i));
    cen = 1'b1;
    step();
    step();
    chk("flush_pre_level", {28'd0, level}, 32'd4);
    flush = 1'b1;
    push(8'h4F, 8'hDF);
    flush = 1'b0;
    chk("flush_level0", {28'd0, level}, 32'd0);
    cen_mode = 1;
    drain();
    words.delete();
    words.push_back({8'h40, 8'hD0});
    check_log(words);

    // Async reset while the data strobe is on the bus.
    do_reset();
    cen_mode = 1;
    push(8'h12, 8'h34);
    guard = 0;
    while (!(e_cs_n == 1'b0 && e_a0 == 1'b1) && guard < 200) begin
      step();
      guard++;
    end
    chk("reach_data_strobe", {31'd0, opll_cs_n}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {28'd0, opll_cs_n, opll_wr_n, level == 4'd0, busy}, {28'd0, 4'b1110});
    #2;
    rst = 1'b0;
    model_reset();
    push(8'h10, 8'h55);
    drain();
    words.delete();
    words.push_back({8'h10, 8'h55});
    check_log(words);

    // cen held low for 50 clocks during the address strobe.
    do_reset();
    cen = 1'b1;
    push(8'h77, 8'h88);
    step();
    cen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("cen_hold_strobe", {31'd0, opll_cs_n}, 32'd0);
    end
    cen = 1'b1;
    step();
    chk("cen_resume_last", {31'd0, opll_cs_n}, 32'd0);
    step();
    chk("cen_resume_release", {31'd0, opll_cs_n}, 32'd1);
    cen_mode = 1;
    drain();
    words.delete();
    words.push_back({8'h77, 8'h88});
    check_log(words);

    // Randomized traffic with random cen and occasional flush.
    do_reset();
    cen_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      wr_if.in_valid = ($urandom_range(0, 2) != 0);
      wr_if.in_reg = 8'($urandom);
      wr_if.in_data = 8'($urandom);
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opll_reg_write_queue.md
Name: opll_reg_write_queue

Overview:
- Buffered CPU-bus front end for the YM2413-compatible OPLL core on the TinyTapeout tile.
- Accepts register-write requests (register address and data) through a valid/ready handshake and stores them in a FIFO.
- Replays each request on the OPLL CPU bus as an address strobe, then a data strobe, inserting the chip-mandated wait times between them.
- Replaces hand-timed ui_in bit-banging. Wait lengths, FIFO depth and strobe length are parametrised.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
ADDR_WAIT, 12, cen ticks between the address strobe end and the data strobe; at least 1.
DATA_WAIT, 84, cen ticks after the data strobe before the next entry; at least 1.
STROBE_LEN, 1, cen ticks each strobe is held; at least 1.
CNT_W, 7, wait-counter width; must hold max(ADDR_WAIT, DATA_WAIT, STROBE_LEN).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous reset, active-high.
cen  in  1  OPLL master-clock enable; all wait and strobe timing counts cycles with cen=1.
in_valid  in  1  write request valid.
in_ready  out  1  FIFO not full; a push occurs when in_valid & in_ready.
in_reg  in  8  OPLL register address.
in_data  in  8  register data.
flush  in  1  discards all queued entries.
opll_cs_n  out  1  chip select, active-low.
opll_wr_n  out  1  write strobe, active-low.
opll_a0  out  1  0 = address phase, 1 = data phase.
opll_d  out  8  bus data.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
busy  out  1  state != IDLE or level != 0.

Behaviour:
- Reset, asynchronous: state IDLE, FIFO empty, level=0, in_ready=1, busy=0, opll_cs_n=1, opll_wr_n=1, opll_a0=0, opll_d=0.
- Reset mid-transaction aborts the bus cycle immediately; the strobe is not completed.
- All outputs are registered.
- FIFO: synchronous, first-word fall-through to the FSM.
  - Simultaneous push and pop leaves level unchanged.
  - in_ready = (level != DEPTH). When full, in_valid is ignored; no data is lost and no error flag is raised.
- FSM states: IDLE, ADDR_STB, ADDR_WAIT, DATA_STB, DATA_WAIT.
- IDLE: if level != 0, pop the head into a hold register and go to ADDR_STB. Outputs on the next edge: cs_n=0, wr_n=0, a0=0, d=reg.
- ADDR_STB: held for STROBE_LEN cen ticks, minimum 1 clk. Then cs_n=1, wr_n=1; go to ADDR_WAIT.
- ADDR_WAIT: counter loaded with ADDR_WAIT on entry, decremented on each cen. On the cen where the counter equals 1, go to DATA_STB with cs_n=0, wr_n=0, a0=1, d=data.
- DATA_STB: same timing as ADDR_STB, then go to DATA_WAIT. opll_d keeps the data value until the next address strobe.
- DATA_WAIT: counter loaded with DATA_WAIT; on the final cen go to IDLE.
- Latency: a push accepted at edge k into an empty, idle queue gives cs_n low after edge k+2. Edge k+1 is the pop; edge k+2 is the registered output.
- Back-to-back entries incur no extra idle cycle beyond the IDLE pop clock.
- cen held low freezes all counters and states indefinitely; strobes stay asserted.
- flush:
  - Clears the FIFO (level=0 next edge); a push in the same cycle is discarded.
  - Does not abort the in-flight transaction, which completes both phases and waits.
- Counter arithmetic is unsigned CNT_W bits; it never wraps, because a load always precedes a decrement.

Decomposition:
- Shared package opll_bus_pkg holds:
  - the FSM state enum;
  - default wait constants OPLL_ADDR_WAIT=12 and OPLL_DATA_WAIT=84;
  - a packed struct {reg[7:0], data[7:0]} for the FIFO word.
- One sub-module: opll_wr_fifo, a parametrised DEPTH x 16 synchronous FIFO with push, pop, flush and level.
- FSM and counters live in the top module.

Test Plan:
- Bench parameters for all scenarios unless stated: ADDR_WAIT=3, DATA_WAIT=5, STROBE_LEN=1, cen every 2nd clk.
- Single write: push reg 0x10, data 0x55 -> cs_n/wr_n low with a0=0, d=0x10 for 1 cen tick; then high for 3 cen; then low with a0=1, d=0x55 for 1 cen; busy falls after 5 more cen ticks.
- Fill: push 9 entries with DEPTH=8 and cen=0 -> in_ready=0 after the 8th accepted push (level=8, since the 1st is popped only when IDLE sees it); the 9th is held off; enabling cen drains all entries in push order with correct a0/d sequence.
- Simultaneous push and pop at level=3 -> level stays 3; the entry order on the bus is preserved.
- Flush during ADDR_WAIT with 4 queued -> level=0 next edge; the current data strobe still issues; no further strobes follow; busy falls after DATA_WAIT.
- Async reset asserted during DATA_STB -> cs_n=1, wr_n=1, level=0, busy=0 without waiting for a clock edge; the next push after release behaves as the single-write case.
- cen held low for 50 clk during ADDR_STB -> cs_n stays 0 the whole time; timing resumes exactly when cen returns.
